alu_arbiter: RTL and testbench

//  Shares the single 8-bit ALU between two requesters: port 0 is the core datapath, port 1 is the

---
 rtl/nrisc_pkg.sv | 12 +
 rtl/rr_arbiter2.sv | 18 +
 rtl/alu_arbiter.sv | 113 +++++++++++
 tb/tb_alu_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nrisc_pkg.sv
// rtl/nrisc_pkg.sv - shared widths and arbiter FSM state encodings
package nrisc_pkg;
   localparam int WIDTH_DFLT = 8;
   localparam int OPW_DFLT   = 3;
   localparam int SHW_DFLT   = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-input grant logic, round-robin or fixed priority
module rr_arbiter2 (
   input  logic [1:0] req_i,
   input  logic       fixed_prio_i,
   input  logic       last_grant_i,
   output logic [1:0] grant_o
);
   // last_grant_i names the port served last; on a tie the other port wins
   always_comb begin
      grant_o = 2'b00;
      case (req_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11:   grant_o = (fixed_prio_i || last_grant_i) ? 2'b01 : 2'b10;
         default: grant_o = 2'b00;
      endcase
   end
endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - shares one ALU between core (port 0) and aux (port 1) requesters
module alu_arbiter
   import nrisc_pkg::*;
#(
   parameter int WIDTH       = WIDTH_DFLT,
   parameter int OPW         = OPW_DFLT,
   parameter int SHW         = SHW_DFLT,
   parameter int ALU_LATENCY = 1,
   parameter int FIXED_PRIO  = 0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [OPW-1:0]   req_op0,
   input  logic [OPW-1:0]   req_op1,
   input  logic [WIDTH-1:0] req_a0,
   input  logic [WIDTH-1:0] req_a1,
   input  logic [WIDTH-1:0] req_b0,
   input  logic [WIDTH-1:0] req_b1,
   input  logic [SHW-1:0]   req_shamt0,
   input  logic [SHW-1:0]   req_shamt1,
   output logic [1:0]       resp_valid,
   output logic [WIDTH-1:0] resp_data,
   output logic             resp_zero,
   output logic             busy,
   output logic [OPW-1:0]   alu_control,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [SHW-1:0]   alu_shamt,
   input  logic [WIDTH-1:0] alu_out,
   input  logic             alu_zero
);
   localparam logic [2:0] LAT_LOAD = 3'(ALU_LATENCY);

   state_t           state_q;
   logic             owner_q;
   logic             last_grant_q;
   logic [2:0]       cnt_q;
   logic [1:0]       resp_valid_q;
   logic [WIDTH-1:0] resp_data_q;
   logic             resp_zero_q;
   logic [OPW-1:0]   alu_control_q;
   logic [WIDTH-1:0] alu_a_q;
   logic [WIDTH-1:0] alu_b_q;
   logic [SHW-1:0]   alu_shamt_q;
   logic [1:0]       grant;
   logic             sel_d;

   rr_arbiter2 u_arb (
      .req_i        (req_valid),
      .fixed_prio_i (FIXED_PRIO != 0),
      .last_grant_i (last_grant_q),
      .grant_o      (grant)
   );

   assign req_ready = (state_q == ST_IDLE) ? grant : 2'b00;
   assign sel_d     = req_ready[1];

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         owner_q       <= 1'b0;
         last_grant_q  <= 1'b1;
         cnt_q         <= 3'd0;
         resp_valid_q  <= 2'b00;
         resp_data_q   <= '0;
         resp_zero_q   <= 1'b0;
         alu_control_q <= '0;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         alu_shamt_q   <= '0;
      end else begin
         resp_valid_q <= 2'b00;
         case (state_q)
            ST_IDLE: begin
               if (|req_ready) begin
                  owner_q       <= sel_d;
                  last_grant_q  <= sel_d;
                  alu_control_q <= sel_d ? req_op1    : req_op0;
                  alu_a_q       <= sel_d ? req_a1     : req_a0;
                  alu_b_q       <= sel_d ? req_b1     : req_b0;
                  alu_shamt_q   <= sel_d ? req_shamt1 : req_shamt0;
                  cnt_q         <= LAT_LOAD;
                  state_q       <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               // Capture on the final counted cycle so the pulse lands at T+ALU_LATENCY+1
               if (cnt_q == 3'd1) begin
                  resp_data_q  <= alu_out;
                  resp_zero_q  <= alu_zero;
                  resp_valid_q <= {owner_q, ~owner_q};
                  state_q      <= ST_RESP;
               end else begin
                  cnt_q <= cnt_q - 3'd1;
               end
            end
            ST_RESP: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign resp_valid  = resp_valid_q;
   assign resp_data   = resp_data_q;
   assign resp_zero   = resp_zero_q;
   assign busy        = (state_q != ST_IDLE);
   assign alu_control = alu_control_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_shamt   = alu_shamt_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench: default, fixed-priority and latency-3 instances
module tb_alu_arbiter;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [1:0] req_valid [3];
   logic [1:0] req_ready [3];
   logic [2:0] op0 [3], op1 [3], sh0 [3], sh1 [3];
   logic [7:0] a0 [3], a1 [3], b0 [3], b1 [3];
   logic [1:0] resp_valid [3];
   logic [7:0] resp_data [3];
   logic       resp_zero [3];
   logic       busy [3];
   logic [2:0] alu_control [3], alu_shamt [3];
   logic [7:0] alu_a [3], alu_b [3], alu_out [3];
   logic       alu_zero [3];

   int checks = 0;
   int errors = 0;

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : g_dut
         alu_arbiter #(
            .WIDTH(8), .OPW(3), .SHW(3),
            .ALU_LATENCY((g == 2) ? 3 : 1),
            .FIXED_PRIO((g == 1) ? 1 : 0)
         ) u_dut (
            .clock(clk), .reset(rst_n),
            .req_valid(req_valid[g]), .req_ready(req_ready[g]),
            .req_op0(op0[g]), .req_op1(op1[g]),
            .req_a0(a0[g]), .req_a1(a1[g]),
            .req_b0(b0[g]), .req_b1(b1[g]),
            .req_shamt0(sh0[g]), .req_shamt1(sh1[g]),
            .resp_valid(resp_valid[g]), .resp_data(resp_data[g]),
            .resp_zero(resp_zero[g]), .busy(busy[g]),
            .alu_control(alu_control[g]), .alu_a(alu_a[g]), .alu_b(alu_b[g]),
            .alu_shamt(alu_shamt[g]), .alu_out(alu_out[g]), .alu_zero(alu_zero[g])
         );
         assign alu_out[g]  = alu_a[g] + alu_b[g];
         assign alu_zero[g] = (alu_out[g] == 8'h00);
      end
   endgenerate

   typedef struct {
      logic       port;
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] sh;
      logic [7:0] exp_d;
      logic       exp_z;
   } vec_t;
   vec_t vecs [5];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input int d, input logic port, input logic [2:0] op,
                        input logic [7:0] a, input logic [7:0] b, input logic [2:0] sh);
      if (port) begin
         op1[d] = op; a1[d] = a; b1[d] = b; sh1[d] = sh;
      end else begin
         op0[d] = op; a0[d] = a; b0[d] = b; sh0[d] = sh;
      end
      req_valid[d][port] = 1'b1;
   endtask

   task automatic clear_all();
      for (int d = 0; d < 3; d++) req_valid[d] = 2'b00;
   endtask

   task automatic check_reset_outputs(input int d, input string tag);
      chk({tag, "_ready"}, req_ready[d], 2'b00);
      chk({tag, "_resp_valid"}, resp_valid[d], 2'b00);
      chk({tag, "_busy"}, busy[d], 1'b0);
      chk({tag, "_resp_data"}, resp_data[d], 8'h00);
      chk({tag, "_resp_zero"}, resp_zero[d], 1'b0);
      chk({tag, "_alu_ctl"}, alu_control[d], 3'd0);
      chk({tag, "_alu_a"}, alu_a[d], 8'h00);
      chk({tag, "_alu_b"}, alu_b[d], 8'h00);
      chk({tag, "_alu_shamt"}, alu_shamt[d], 3'd0);
   endtask

   // Both ports held valid; each op must grant exp_seq-th port and return its result
   task automatic run_both(input int d, input int nops, input logic fixed);
      logic [1:0] expg;
      for (int k = 0; k < nops; k++) begin
         int t = 0;
         expg = (fixed || k[0] == 1'b0) ? 2'b01 : 2'b10;
         @(negedge clk);
         while (req_ready[d] == 2'b00 && t < 10) begin
            @(negedge clk);
            t++;
         end
         if (t >= 10) chk("both_timeout", 32'(t), 32'd0);
         chk("both_grant", req_ready[d], expg);
         @(negedge clk);
         @(negedge clk);
         chk("both_resp_valid", resp_valid[d], expg);
         chk("both_resp_data", resp_data[d], (expg == 2'b01) ? 8'h04 : 8'h00);
         chk("both_resp_zero", resp_zero[d], (expg == 2'b01) ? 1'b0 : 1'b1);
      end
      @(posedge clk); #1;
      clear_all();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int d = 0; d < 3; d++) begin
         req_valid[d] = 2'b00;
         op0[d] = 0; op1[d] = 0; sh0[d] = 0; sh1[d] = 0;
         a0[d] = 0; a1[d] = 0; b0[d] = 0; b1[d] = 0;
      end
      vecs[0] = '{1'b0, 3'd0, 8'h02, 8'h02, 3'd0, 8'h04, 1'b0};
      vecs[1] = '{1'b1, 3'd5, 8'hFF, 8'h01, 3'd7, 8'h00, 1'b1};
      vecs[2] = '{1'b0, 3'd2, 8'h80, 8'h80, 3'd3, 8'h00, 1'b1};
      vecs[3] = '{1'b1, 3'd1, 8'h00, 8'h00, 3'd1, 8'h00, 1'b1};
      vecs[4] = '{1'b0, 3'd7, 8'h12, 8'h34, 3'd6, 8'h46, 1'b0};

      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs(0, "rst_hold");
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs(0, "rst_rel");
      check_reset_outputs(2, "rst_rel_l3");

      // round-robin: tie goes to port 0 first after reset, then alternates
      @(posedge clk); #1;
      drive(0, 1'b0, 3'd0, 8'h02, 8'h02, 3'd0);
      drive(0, 1'b1, 3'd0, 8'hFF, 8'h01, 3'd0);
      run_both(0, 4, 1'b0);

      for (int i = 0; i < 5; i++) begin
         logic [1:0] oh;
         oh = vecs[i].port ? 2'b10 : 2'b01;
         @(posedge clk); #1;
         drive(0, vecs[i].port, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh);
         @(negedge clk);
         chk("vec_ready", req_ready[0], oh);
         chk("vec_busy_T", busy[0], 1'b0);
         @(posedge clk); #1;
         clear_all();
         @(negedge clk);
         chk("vec_busy_T1", busy[0], 1'b1);
         chk("vec_resp_T1", resp_valid[0], 2'b00);
         chk("vec_ready_T1", req_ready[0], 2'b00);
         chk("vec_alu_a", alu_a[0], vecs[i].a);
         chk("vec_alu_b", alu_b[0], vecs[i].b);
         chk("vec_alu_ctl", alu_control[0], vecs[i].op);
         chk("vec_alu_shamt", alu_shamt[0], vecs[i].sh);
         @(negedge clk);
         chk("vec_resp_valid", resp_valid[0], oh);
         chk("vec_resp_data", resp_data[0], vecs[i].exp_d);
         chk("vec_resp_zero", resp_zero[0], vecs[i].exp_z);
         chk("vec_busy_T2", busy[0], 1'b1);
         @(negedge clk);
         chk("vec_resp_T3", resp_valid[0], 2'b00);
         chk("vec_busy_T3", busy[0], 1'b0);
         chk("vec_hold_data", resp_data[0], vecs[i].exp_d);
         chk("vec_hold_alu_a", alu_a[0], vecs[i].a);
      end

      // fixed priority: port 1 must never be granted
      @(posedge clk); #1;
      drive(1, 1'b0, 3'd0, 8'h02, 8'h02, 3'd0);
      drive(1, 1'b1, 3'd0, 8'hFF, 8'h01, 3'd0);
      run_both(1, 10, 1'b1);

      // latency 3: port 1 at T, port 0 arrives during EXEC
      @(posedge clk); #1;
      drive(2, 1'b1, 3'd0, 8'h10, 8'h20, 3'd0);
      @(negedge clk);
      chk("l3_ready_T", req_ready[2], 2'b10);
      @(posedge clk); #1;
      clear_all();
      drive(2, 1'b0, 3'd0, 8'h01, 8'h01, 3'd0);
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         chk("l3_no_resp", resp_valid[2], 2'b00);
         chk("l3_no_ready", req_ready[2], 2'b00);
         chk("l3_busy", busy[2], 1'b1);
      end
      @(negedge clk);
      chk("l3_resp_T4", resp_valid[2], 2'b10);
      chk("l3_data_T4", resp_data[2], 8'h30);
      chk("l3_ready_T4", req_ready[2], 2'b00);
      @(negedge clk);
      chk("l3_ready_T5", req_ready[2], 2'b01);
      @(posedge clk); #1;
      clear_all();
      repeat (3) begin
         @(negedge clk);
         chk("l3b_no_resp", resp_valid[2], 2'b00);
      end
      @(negedge clk);
      chk("l3b_resp", resp_valid[2], 2'b01);
      chk("l3b_data", resp_data[2], 8'h02);

      // reset in EXEC discards the op
      @(posedge clk); #1;
      drive(0, 1'b0, 3'd1, 8'h05, 8'h06, 3'd2);
      @(posedge clk); #1;
      clear_all();
      @(negedge clk);
      chk("mid_busy_before", busy[0], 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check_reset_outputs(0, "mid_rst");
      @(negedge clk);
      chk("mid_no_resp", resp_valid[0], 2'b00);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      drive(0, 1'b1, 3'd0, 8'h03, 8'h04, 3'd0);
      @(negedge clk);
      chk("post_ready", req_ready[0], 2'b10);
      @(posedge clk); #1;
      clear_all();
      @(negedge clk);
      chk("post_resp_T1", resp_valid[0], 2'b00);
      @(negedge clk);
      chk("post_resp", resp_valid[0], 2'b10);
      chk("post_data", resp_data[0], 8'h07);
      chk("post_zero", resp_zero[0], 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
